// File: rtl/axil_wr_arbiter.sv
// axil_wr_arbiter: round-robin arbiter that lets S_COUNT AXI-lite write
// requesters share a single AXI-lite write slave. One transaction is in
// flight at a time; AW and W of the owner are forwarded independently and the
// B response is routed back to the owner only.
module axil_wr_arbiter #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [S_COUNT*3-1:0]             s_axil_awprot,
    input  logic [S_COUNT-1:0]               s_axil_awvalid,
    output logic [S_COUNT-1:0]               s_axil_awready,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_wdata,
    input  logic [S_COUNT*STRB_WIDTH-1:0]    s_axil_wstrb,
    input  logic [S_COUNT-1:0]               s_axil_wvalid,
    output logic [S_COUNT-1:0]               s_axil_wready,
    output logic [S_COUNT*2-1:0]             s_axil_bresp,
    output logic [S_COUNT-1:0]               s_axil_bvalid,
    input  logic [S_COUNT-1:0]               s_axil_bready,

    output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
    output logic [2:0]                       m_axil_awprot,
    output logic                             m_axil_awvalid,
    input  logic                             m_axil_awready,
    output logic [DATA_WIDTH-1:0]            m_axil_wdata,
    output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
    output logic                             m_axil_wvalid,
    input  logic                             m_axil_wready,
    input  logic [1:0]                       m_axil_bresp,
    input  logic                             m_axil_bvalid,
    output logic                             m_axil_bready,

    output logic                             grant_valid,
    output logic [$clog2(S_COUNT)-1:0]       grant_index
);

    localparam int IDX_W = $clog2(S_COUNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;

    logic              in_xfer;
    logic              in_resp;
    logic              aw_open;
    logic              w_open;

    logic              rr_found;
    logic [IDX_W-1:0]  rr_pick;
    logic              hi_found;
    logic [IDX_W-1:0]  hi_pick;
    logic              lo_found;
    logic [IDX_W-1:0]  lo_pick;

    logic [ADDR_WIDTH-1:0] sel_awaddr;
    logic [2:0]            sel_awprot;
    logic                  sel_awvalid;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;
    logic                  sel_wvalid;
    logic                  sel_bready;

    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;

    assign in_xfer = (state_q == ST_XFER);
    assign in_resp = (state_q == ST_RESP);
    assign aw_open = in_xfer && !aw_done_q;
    assign w_open  = in_xfer && !w_done_q;

    // Round-robin search: lowest requesting index above last_grant wins,
    // otherwise wrap around and take the lowest requesting index at or below it.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_found = 1'b0;
        lo_pick  = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_axil_awvalid[i]) begin
                if (IDX_W'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_pick  = IDX_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_pick  = IDX_W'(i);
                end
            end
        end
        rr_found = hi_found || lo_found;
        rr_pick  = hi_found ? hi_pick : lo_pick;
    end

    // Select the owner's AW, W and bready signals out of the flattened buses.
    always_comb begin
        sel_awaddr  = '0;
        sel_awprot  = '0;
        sel_awvalid = 1'b0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_awaddr  = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_awprot  = s_axil_awprot[i*3 +: 3];
                sel_awvalid = s_axil_awvalid[i];
                sel_wdata   = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb   = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
                sel_wvalid  = s_axil_wvalid[i];
                sel_bready  = s_axil_bready[i];
            end
        end
    end

    // Master-side outputs: each channel is forwarded only while it is still open.
    always_comb begin
        m_axil_awaddr  = aw_open ? sel_awaddr : '0;
        m_axil_awprot  = aw_open ? sel_awprot : '0;
        m_axil_awvalid = aw_open && sel_awvalid;
        m_axil_wdata   = w_open ? sel_wdata : '0;
        m_axil_wstrb   = w_open ? sel_wstrb : '0;
        m_axil_wvalid  = w_open && sel_wvalid;
        m_axil_bready  = in_resp && sel_bready;
    end

    // Requester-side outputs: only the owner ever sees ready or a response.
    always_comb begin
        s_axil_awready = '0;
        s_axil_wready  = '0;
        s_axil_bvalid  = '0;
        s_axil_bresp   = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q == IDX_W'(i)) begin
                s_axil_awready[i]      = aw_open && m_axil_awready;
                s_axil_wready[i]       = w_open && m_axil_wready;
                s_axil_bvalid[i]       = in_resp && m_axil_bvalid;
                s_axil_bresp[i*2 +: 2] = in_resp ? m_axil_bresp : 2'b00;
            end
        end
    end

    assign aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_hs  = m_axil_wvalid && m_axil_wready;
    assign b_hs  = m_axil_bvalid && m_axil_bready;

    // Next-state logic for the IDLE -> XFER -> RESP -> IDLE transaction cycle.
    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d   = rr_pick;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction and makes index 0 win next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(S_COUNT - 1);
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_valid = in_xfer || in_resp;
    assign grant_index = grant_q;

endmodule

// File: doc/axil_wr_arbiter.md
AXIL_WR_ARBITER -- requirements
Module: axil_wr_arbiter

Interface
REQ-001 SHALL have parameter S_COUNT, default 2, number of AXI-lite write requesters (legal 2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, wstrb width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports s_axil_awaddr/awprot/awvalid/awready  in/in/in/out  S_COUNT*ADDR_WIDTH / S_COUNT*3 / S_COUNT / S_COUNT  flattened per-requester AW channels, requester i at slice i.
REQ-008 SHALL have ports s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  S_COUNT*DATA_WIDTH / S_COUNT*STRB_WIDTH / S_COUNT / S_COUNT  per-requester W channels.
REQ-009 SHALL have ports s_axil_bresp/bvalid/bready  out/out/in  S_COUNT*2 / S_COUNT / S_COUNT  per-requester B channels.
REQ-010 SHALL have ports m_axil_awaddr/awprot/awvalid/awready, m_axil_wdata/wstrb/wvalid/wready, m_axil_bresp/bvalid/bready  with single-port widths and standard AXI-lite directions toward the shared slave.
REQ-011 SHALL have port grant_valid  output  1  a transaction owns the master port.
REQ-012 SHALL have port grant_index  output  $clog2(S_COUNT)  index of current/last owner.

Function
REQ-013 SHALL use a registered FSM with states IDLE, XFER, RESP.
REQ-014 Request of requester i SHALL be s_axil_awvalid[i]; wvalid is not part of the request.
REQ-015 In IDLE with any request, SHALL select by round-robin: first requesting index searching upward from (last_grant+1) mod S_COUNT, wrapping; register grant_index, go to XFER next cycle.
REQ-016 last_grant SHALL reset to S_COUNT-1 so index 0 wins first arbitration.
REQ-017 In XFER, m_axil_aw* SHALL combinationally mirror the granted requester's AW while aw_done=0; m_axil_awvalid=0 once aw_done=1.
REQ-018 In XFER, m_axil_w* SHALL mirror the granted requester's W while w_done=0; m_axil_wvalid=0 once w_done=1.
REQ-019 s_axil_awready[g]=m_axil_awready in XFER with aw_done=0; same for wready/w_done; all other s_*ready SHALL be 0.
REQ-020 aw_done/w_done SHALL set on the respective master handshake and clear on entry to XFER; AW and W may complete in either order or same cycle.
REQ-021 XFER->RESP SHALL occur on the cycle after both done flags are set (or both handshakes complete in the same cycle).
REQ-022 m_axil_bready SHALL be 0 outside RESP; m_axil_bvalid in IDLE/XFER is ignored.
REQ-023 In RESP, s_axil_bvalid[g]=m_axil_bvalid, s_axil_bresp[g]=m_axil_bresp, m_axil_bready=s_axil_bready[g]; other s_axil_bvalid SHALL be 0.
REQ-024 On B handshake in RESP, SHALL update last_grant=g and go to IDLE; earliest re-arbitration next cycle (one idle cycle between transactions).
REQ-025 Only one transaction SHALL be outstanding; minimum latency request-to-master-awvalid is 1 cycle.
REQ-026 Non-granted requesters SHALL see ready=0 and bvalid=0 indefinitely; their requests are held, never dropped.
REQ-027 grant_valid SHALL be 1 in XFER and RESP, else 0; grant_index holds last owner in IDLE.
REQ-028 Requester deasserting awvalid before handshake is a protocol violation; behaviour undefined.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, aw_done=w_done=0, grant_index=0, last_grant=S_COUNT-1, grant_valid=0.
REQ-030 During/after reset all m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_axil_awready, s_axil_wready, s_axil_bvalid SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon it without completing B to any requester.
REQ-032 Release of rst_n SHALL be synchronized externally; block requires no internal synchronizer.

Verification
REQ-033 Single request: req 1 writes addr 0x10 data 0xA5A5A5A5, slave accepts AW/W immediately, bresp 2'b00 -> master sees addr/data 1 cycle after awvalid; s_axil_bvalid[1]=1 with bresp 00; grant_index=1.
REQ-034 Simultaneous requests 0 and 1 from reset -> order 0,1,0,1 over four back-to-back writes each; never two consecutive grants to same index while other waits.
REQ-035 Split channels: slave asserts wready 3 cycles before awready -> wvalid dropped after W handshake, awvalid held, RESP entered one cycle after AW handshake.
REQ-036 Slow response: bvalid delayed 5 cycles, granted s_axil_bready=0 for 2 cycles -> m_axil_bready=0 until s_axil_bready=1; other requester's awready stays 0 throughout.
REQ-037 Wrap-around, S_COUNT=4: last_grant=3, requests on 1 and 3 -> grant 1; then last_grant=1, requests 0 and 3 -> grant 3.
REQ-038 Reset asserted in XFER after AW handshake only -> all valids/readies 0 immediately; after release, new request from 0 proceeds normally with fresh AW and W.
